// File: rtl/cmos_split.sv
// Splits one stitched RGB565 line into left/right half-lines emitted side by side.
// The left half is held in a HALF_W-word line RAM and is read out while the right half streams in.
module cmos_split #(
    parameter int HALF_W  = 960,
    parameter int OVERLAP = 20,
    parameter int DATA_W  = 16
) (
    input  logic              pclk,
    input  logic              sys_rst,
    input  logic              in_vsync,
    input  logic              in_href,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vsync,
    output logic              out_href,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              line_err,
    output logic [11:0]       line_cnt
);
    localparam int IN_W    = 2*HALF_W - OVERLAP;
    localparam int R_START = IN_W - HALF_W;
    localparam int COL_W   = $clog2(IN_W + 1);
    localparam int AW      = $clog2(HALF_W);
    localparam logic [COL_W-1:0] C_IN_W  = COL_W'(IN_W);
    localparam logic [COL_W-1:0] C_RSTRT = COL_W'(R_START);
    localparam logic [COL_W-1:0] C_HALF  = COL_W'(HALF_W);

    typedef enum logic [1:0] {IDLE, FILL, PAIR, DRAIN} state_t;

    state_t           state, state_eff, state_nxt;
    logic [COL_W-1:0] col, col_eff, col_nxt;
    logic             vsync_d, vs_rise;
    logic             armed, armed_nxt;
    logic             ovr_seen, ovr_nxt;
    logic             take, done, err_nxt;
    logic             wr_en, rd_en;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [DATA_W-1:0] ram [HALF_W];

    assign vs_rise   = in_vsync & ~vsync_d;
    assign out_vsync = vsync_d;

    // A vsync rise drops any line in flight; the same cycle is then judged as IDLE,
    // so a line starting together with the vsync rise is still captured.
    always_comb begin
        state_eff = vs_rise ? IDLE : state;
        state_nxt = state_eff;
        col_eff   = col;
        col_nxt   = col;
        take      = 1'b0;
        done      = 1'b0;
        err_nxt   = 1'b0;
        armed_nxt = armed | ~in_href;
        ovr_nxt   = ovr_seen;
        unique case (state_eff)
            IDLE: begin
                if (in_href && armed) begin
                    take      = 1'b1;
                    col_eff   = '0;
                    armed_nxt = 1'b0;
                end
            end
            FILL, PAIR: begin
                if (in_href) begin
                    take = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            DRAIN: begin
                if (in_href) begin
                    ovr_nxt = 1'b1;
                    err_nxt = ~ovr_seen;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
        if (take) begin
            col_nxt = col_eff + 1'b1;
            if (col_nxt == C_IN_W) begin
                state_nxt = DRAIN;
                done      = 1'b1;
                ovr_nxt   = 1'b0;
            end else if (col_nxt >= C_RSTRT) begin
                state_nxt = PAIR;
            end else begin
                state_nxt = FILL;
            end
        end
    end

    assign wr_en   = take && (col_eff < C_HALF);
    assign rd_en   = take && (col_eff >= C_RSTRT);
    assign wr_addr = AW'(col_eff);
    assign rd_addr = AW'(col_eff - C_RSTRT);

    always_ff @(posedge pclk) begin
        if (wr_en) ram[wr_addr] <= in_data;
    end

    always_ff @(posedge pclk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            col        <= '0;
            vsync_d    <= 1'b0;
            armed      <= 1'b0;
            ovr_seen   <= 1'b0;
            out_href   <= 1'b0;
            left_data  <= '0;
            right_data <= '0;
            line_err   <= 1'b0;
            line_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            vsync_d    <= in_vsync;
            armed      <= armed_nxt;
            ovr_seen   <= ovr_nxt;
            out_href   <= rd_en;
            left_data  <= rd_en ? ram[rd_addr] : '0;
            right_data <= rd_en ? in_data : '0;
            line_err   <= err_nxt;
            if (vs_rise)
                line_cnt <= '0;
            else if (done && line_cnt != 12'hFFF)
                line_cnt <= line_cnt + 12'd1;
        end
    end
endmodule

// File: tb/tb_cmos_split.sv
// Scoreboard bench for cmos_split: driver queues expected pairs, monitor pops and compares.
module tb_cmos_split;
    localparam int HALF_W  = 960;
    localparam int OVERLAP = 20;
    localparam int IN_W    = 2*HALF_W - OVERLAP;
    localparam int R_START = IN_W - HALF_W;

    logic        pclk = 1'b0;
    logic        rst;
    logic        in_vsync, in_href;
    logic [15:0] in_data;
    logic        out_vsync, out_href, line_err;
    logic [15:0] left_data, right_data;
    logic [11:0] line_cnt;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   err_cnt = 0;
    logic vs_prev = 1'b0;

    cmos_split #(.HALF_W(HALF_W), .OVERLAP(OVERLAP), .DATA_W(16)) dut (
        .pclk(pclk), .sys_rst(rst), .in_vsync(in_vsync), .in_href(in_href),
        .in_data(in_data), .out_vsync(out_vsync), .out_href(out_href),
        .left_data(left_data), .right_data(right_data), .line_err(line_err),
        .line_cnt(line_cnt)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) begin
        cyc     <= cyc + 1;
        vs_prev <= in_vsync;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge pclk) begin
        if (!rst) begin
            if (out_href) begin
                if (q.size() == 0) begin
                    chk("unexpected_pair", 32'(left_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("left_data", 32'(left_data), 32'(e.l));
                    chk("right_data", 32'(right_data), 32'(e.r));
                    chk("pair_cycle", 32'(cyc), 32'(e.c));
                end
            end else begin
                chk("idle_data_zero", {left_data, right_data}, 32'h0);
            end
            if (line_err) err_cnt++;
            chk("out_vsync", 32'(out_vsync), 32'(vs_prev));
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        in_href = 1'b0;
        in_data = '0;
        repeat (n) step();
    endtask

    // Drives len columns with data = column index; pairs from columns >= cut are not expected.
    task automatic drive_line(input int len, input int cut, input int vs_on, input int vs_off,
                              input int rst_on, input int rst_off);
        for (int c = 0; c < len; c++) begin
            in_href = 1'b1;
            in_data = 16'(c);
            if (c == vs_on)   in_vsync = 1'b1;
            if (c == vs_off)  in_vsync = 1'b0;
            if (c == rst_off) rst = 1'b0;
            if (c == rst_on) begin
                rst = 1'b1;
                #1;
                chk("rst_out_href", 32'(out_href), 32'h0);
                chk("rst_line_cnt", 32'(line_cnt), 32'h0);
                chk("rst_data", {left_data, right_data}, 32'h0);
            end
            if (c >= R_START && c < IN_W && c < cut)
                q.push_back('{l: 16'(c - R_START), r: 16'(c), c: cyc + 1});
            step();
        end
        in_href = 1'b0;
        in_data = '0;
    endtask

    task automatic full_line();
        drive_line(IN_W, IN_W, -1, -1, -1, -1);
        idle(6);
    endtask

    task automatic vsync_pulse();
        in_vsync = 1'b1;
        repeat (4) step();
        in_vsync = 1'b0;
        idle(4);
    endtask

    int e0;

    initial begin
        rst = 1'b1; in_vsync = 1'b0; in_href = 1'b0; in_data = '0;
        #1;
        chk("reset_out_href", 32'(out_href), 32'h0);
        chk("reset_data", {left_data, right_data}, 32'h0);
        chk("reset_line_err", 32'(line_err), 32'h0);
        chk("reset_line_cnt", 32'(line_cnt), 32'h0);
        chk("reset_out_vsync", 32'(out_vsync), 32'h0);
        repeat (3) step();
        rst = 1'b0;
        idle(4);

        // clean line, includes overlap columns 940..959 on both halves
        e0 = err_cnt;
        full_line();
        chk("t1_line_cnt", 32'(line_cnt), 32'd1);
        chk("t1_no_err", 32'(err_cnt), 32'(e0));
        chk("t1_queue_empty", 32'(q.size()), 32'd0);

        // early end after 1000 columns: 60 pairs
        drive_line(1000, IN_W, -1, -1, -1, -1);
        idle(6);
        chk("t3_err_once", 32'(err_cnt), 32'(e0 + 1));
        chk("t3_line_cnt", 32'(line_cnt), 32'd1);
        chk("t3_queue_empty", 32'(q.size()), 32'd0);
        full_line();
        chk("t3_next_line_cnt", 32'(line_cnt), 32'd2);

        // overrun by 5 columns
        e0 = err_cnt;
        drive_line(IN_W + 5, IN_W, -1, -1, -1, -1);
        idle(6);
        chk("t4_err_once", 32'(err_cnt), 32'(e0 + 1));
        chk("t4_line_cnt", 32'(line_cnt), 32'd3);

        // reset at column 500, released with href high: line ignored
        e0 = err_cnt;
        drive_line(IN_W, 0, -1, -1, 500, 503);
        idle(6);
        chk("t5_no_output", 32'(q.size()), 32'd0);
        chk("t5_line_cnt", 32'(line_cnt), 32'd0);
        chk("t5_no_err", 32'(err_cnt), 32'(e0));
        full_line();
        chk("t5_next_line_cnt", 32'(line_cnt), 32'd1);

        // frame counting across vsync
        vsync_pulse();
        chk("t6_clear0", 32'(line_cnt), 32'd0);
        repeat (3) full_line();
        chk("t6_three", 32'(line_cnt), 32'd3);
        vsync_pulse();
        chk("t6_clear", 32'(line_cnt), 32'd0);
        full_line();
        chk("t6_one", 32'(line_cnt), 32'd1);

        // vsync rise mid-line discards the rest silently
        e0 = err_cnt;
        drive_line(IN_W, 1000, 1000, 1010, -1, -1);
        idle(6);
        chk("t7_line_cnt", 32'(line_cnt), 32'd0);
        chk("t7_no_err", 32'(err_cnt), 32'(e0));
        chk("t7_queue_empty", 32'(q.size()), 32'd0);

        // vsync rise together with href rise: line captured after the clear
        drive_line(IN_W, IN_W, 0, 10, -1, -1);
        idle(6);
        chk("t8_line_cnt", 32'(line_cnt), 32'd1);
        chk("t8_no_err", 32'(err_cnt), 32'(e0));

        idle(10);
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
